// File: rtl/w0rm_core_imem_if_if.sv
// Signal bundle between the fetch stage, the instruction-memory port and the
// imem interface block. The block itself uses 'master'; its environment uses 'slave'.
interface w0rm_core_imem_if_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int INST_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] reg_pc;
    logic                  reg_pc_valid;
    logic                  req_ready;
    logic                  flush;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_read;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic                  mem_data_valid;
    logic [INST_WIDTH-1:0] inst_data_out;
    logic                  inst_valid_out;
    logic [ADDR_WIDTH-1:0] inst_addr_out;
    logic                  resp_err;

    modport master (
        input  reg_pc, reg_pc_valid, flush, mem_ready, mem_data_in, mem_data_valid,
        output req_ready, mem_addr, mem_read, inst_data_out, inst_valid_out,
        output inst_addr_out, resp_err
    );

    modport slave (
        output reg_pc, reg_pc_valid, flush, mem_ready, mem_data_in, mem_data_valid,
        input  req_ready, mem_addr, mem_read, inst_data_out, inst_valid_out,
        input  inst_addr_out, resp_err
    );
endinterface

// File: rtl/w0rm_core_imem_if.sv
// W0RM instruction-memory interface: issues word-aligned reads, tracks in-flight
// requests in order, and returns the addressed 16-bit half-word to fetch.
module w0rm_core_imem_if #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int INST_WIDTH      = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    w0rm_core_imem_if_if.master bus
);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0]      r_fifo_pc [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] r_fifo_disc;
    logic [PW-1:0]              r_wr_ptr;
    logic [PW-1:0]              r_rd_ptr;
    logic [CW-1:0]              r_count;

    logic                       r_mem_read;
    logic [ADDR_WIDTH-1:0]      r_mem_addr;
    logic [ADDR_WIDTH-1:0]      r_held_pc;
    logic                       r_held_disc;

    logic [INST_WIDTH-1:0]      r_inst_data;
    logic [ADDR_WIDTH-1:0]      r_inst_addr;
    logic                       r_inst_valid;
    logic                       r_resp_err;

    logic                       w_fifo_empty;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_req_ready;
    logic                       w_accept;
    logic [ADDR_WIDTH-1:0]      w_pop_pc;
    logic                       w_pop_disc;
    logic                       w_deliver;
    logic [INST_WIDTH-1:0]      w_sel_inst;

    assign w_fifo_empty = (r_count == '0);
    assign w_push       = r_mem_read & bus.mem_ready;
    assign w_pop        = bus.mem_data_valid & ~w_fifo_empty;

    // Pops are deliberately not credited here; only a same-cycle push is counted.
    assign w_req_ready  = ~bus.flush
                        & (~r_mem_read | bus.mem_ready)
                        & ((r_count + CW'(w_push)) < CW'(MAX_OUTSTANDING));
    assign w_accept     = bus.reg_pc_valid & w_req_ready;

    assign w_pop_pc     = r_fifo_pc[r_rd_ptr];
    assign w_pop_disc   = r_fifo_disc[r_rd_ptr];
    assign w_deliver    = w_pop & ~w_pop_disc & ~bus.flush;
    assign w_sel_inst   = w_pop_pc[1] ? bus.mem_data_in[DATA_WIDTH-1:INST_WIDTH]
                                      : bus.mem_data_in[INST_WIDTH-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                r_fifo_pc[i] <= '0;
            end
            r_fifo_disc  <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_mem_read   <= 1'b0;
            r_mem_addr   <= '0;
            r_held_pc    <= '0;
            r_held_disc  <= 1'b0;
            r_inst_data  <= '0;
            r_inst_addr  <= '0;
            r_inst_valid <= 1'b0;
            r_resp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mem_addr  <= {bus.reg_pc[ADDR_WIDTH-1:2], 2'b00};
                r_mem_read  <= 1'b1;
                r_held_pc   <= bus.reg_pc;
                r_held_disc <= 1'b0;
            end else begin
                if (w_push) begin
                    r_mem_read <= 1'b0;
                end
                // A held request cannot be retracted; remember to drop its response.
                if (bus.flush) begin
                    r_held_disc <= 1'b1;
                end
            end

            if (w_push) begin
                r_fifo_pc[r_wr_ptr]   <= r_held_pc;
                r_fifo_disc[r_wr_ptr] <= r_held_disc | bus.flush;
                r_wr_ptr              <= r_wr_ptr + PW'(1);
            end
            if (bus.flush) begin
                r_fifo_disc <= '1;
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);

            r_inst_valid <= w_deliver;
            if (w_deliver) begin
                r_inst_data <= w_sel_inst;
                r_inst_addr <= w_pop_pc;
            end

            if (bus.mem_data_valid && w_fifo_empty) begin
                r_resp_err <= 1'b1;
            end
        end
    end

    assign bus.req_ready      = w_req_ready;
    assign bus.mem_addr       = r_mem_addr;
    assign bus.mem_read       = r_mem_read;
    assign bus.inst_data_out  = r_inst_data;
    assign bus.inst_valid_out = r_inst_valid;
    assign bus.inst_addr_out  = r_inst_addr;
    assign bus.resp_err       = r_resp_err;
endmodule
